instruction_fetch: RTL and testbench

Fetch stage of the RISC-V core: owns the program counter and issues word requests to instruction memory over a valid/ready port. It buffers returned instruction words, each tagged with its PC, in a small in-order FIFO, and presents them to the decode stage, where the immediate generator consumes them. It supports decode back-pressure and branch/jump redirects, which squash both buffered and in-flight fetches.

---
 rtl/instruction_fetch.sv | 76 +++++++
 tb/tb_instruction_fetch.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch: owns the PC, issues imem requests and buffers PC-tagged words in an in-order FWFT FIFO
module instruction_fetch #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  output logic             o_imem_req_valid,
  output logic [WIDTH-1:0] o_imem_addr,
  input  logic             i_imem_req_ready,
  input  logic             i_imem_rsp_valid,
  input  logic [WIDTH-1:0] i_imem_rsp_data,
  input  logic             i_redirect,
  input  logic [WIDTH-1:0] i_redirect_pc,
  output logic             o_inst_valid,
  output logic [WIDTH-1:0] o_instruction,
  output logic [WIDTH-1:0] o_pc,
  input  logic             i_inst_ready
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [WIDTH-1:0] NOP = WIDTH'(32'h0000_0013);
  logic [WIDTH-1:0] r_pc;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    r_out;
  logic [CW-1:0]    r_drop;
  logic [AW-1:0]    r_rd;
  logic [AW-1:0]    r_wr;
  logic [WIDTH-1:0] r_mem_pc [FIFO_DEPTH];
  logic [WIDTH-1:0] r_mem_data [FIFO_DEPTH];
  logic             w_accept;
  logic             w_rsp;
  logic             w_push;
  logic             w_pop;
  logic             w_room;
  logic [WIDTH-1:0] w_tag;
  // Outstanding plus buffered never exceeds the FIFO size, so every response has a slot
  assign w_room = ({1'b0, r_count} + {1'b0, r_out}) < (CW+1)'(FIFO_DEPTH);
  assign o_imem_req_valid = !i_rst && !i_redirect && w_room;
  assign o_imem_addr = r_pc;
  assign w_accept = o_imem_req_valid && i_imem_req_ready;
  assign w_rsp = i_imem_rsp_valid && (r_out != '0);
  assign w_push = w_rsp && (r_drop == '0) && !i_redirect;
  assign o_inst_valid = (r_count != '0);
  assign w_pop = o_inst_valid && i_inst_ready && !i_redirect;
  // Live in-flight requests are the r_out words fetched contiguously just before r_pc
  assign w_tag = r_pc - (WIDTH'(r_out) << 2);
  assign o_instruction = o_inst_valid ? r_mem_data[r_rd] : NOP;
  assign o_pc = o_inst_valid ? r_mem_pc[r_rd] : '0;
  // PC, in-flight/drop accounting and FIFO pointers; redirect flushes and squashes in-flight words
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pc    <= RESET_PC;
      r_count <= '0;
      r_out   <= '0;
      r_drop  <= '0;
      r_rd    <= '0;
      r_wr    <= '0;
    end else begin
      r_pc    <= i_redirect ? (i_redirect_pc & ~WIDTH'(3)) : w_accept ? r_pc + WIDTH'(4) : r_pc;
      r_out   <= r_out + CW'(w_accept) - CW'(w_rsp);
      r_drop  <= i_redirect ? r_out - CW'(w_rsp) : r_drop - CW'(w_rsp && (r_drop != '0));
      r_count <= i_redirect ? '0 : r_count + CW'(w_push) - CW'(w_pop);
      r_wr    <= r_wr + AW'(w_push);
      r_rd    <= i_redirect ? r_wr : r_rd + AW'(w_pop);
    end
  end
  // Entry storage needs no reset; validity comes from r_count
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem_pc[r_wr]   <= w_tag;
      r_mem_data[r_wr] <= i_imem_rsp_data;
    end
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: randomized bench with a queue-based memory and decode model
module tb_instruction_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } req_t;
  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic [31:0] imem_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        inst_ready;
  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          last_due = -1;
  int          kfix = 1;
  int          n_vld = 0;
  logic [31:0] exp_req_pc = 32'h0;
  logic [31:0] mq[$];
  req_t        pend[$];

  instruction_fetch dut (
    .i_clk(clk), .i_rst(rst),
    .o_imem_req_valid(imem_req_valid), .o_imem_addr(imem_addr), .i_imem_req_ready(imem_req_ready),
    .i_imem_rsp_valid(imem_rsp_valid), .i_imem_rsp_data(imem_rsp_data),
    .i_redirect(redirect), .i_redirect_pc(redirect_pc),
    .o_inst_valid(inst_valid), .o_instruction(instruction), .o_pc(pc), .i_inst_ready(inst_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(logic [31:0] a);
    return a ^ 32'h5A5A_A5A5 ^ {a[15:0], a[31:16]};
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic cycle(bit redir, logic [31:0] tgt, bit mrdy, bit drdy);
    bit   rsp;
    bit   ev;
    req_t p;
    int   d;
    @(negedge clk);
    rsp = (pend.size() != 0) && (pend[0].due == cyc);
    redirect = redir;
    redirect_pc = tgt;
    imem_req_ready = mrdy;
    inst_ready = drdy;
    imem_rsp_valid = rsp;
    imem_rsp_data = rsp ? word(pend[0].addr) : $urandom;
    #1;
    ev = !redir && (mq.size() + pend.size() < 4);
    check("req_valid", {31'b0, imem_req_valid}, {31'b0, ev});
    check("req_addr", imem_addr, exp_req_pc);
    check("inst_valid", {31'b0, inst_valid}, {31'b0, mq.size() != 0});
    check("inst_pc", pc, mq.size() != 0 ? mq[0] : 32'h0);
    check("inst_data", instruction, mq.size() != 0 ? word(mq[0]) : NOP);
    if (inst_valid) n_vld++;
    if (!redir && mq.size() != 0 && drdy) void'(mq.pop_front());
    if (rsp) begin
      p = pend.pop_front();
      if (!p.stale && !redir) mq.push_back(p.addr);
    end
    if (redir) begin
      mq.delete();
      foreach (pend[i]) pend[i].stale = 1'b1;
      exp_req_pc = tgt & ~32'h3;
    end else if (ev && mrdy) begin
      d = cyc + (kfix != 0 ? kfix : int'($urandom_range(3, 1)));
      if (d <= last_due) d = last_due + 1;
      pend.push_back('{exp_req_pc, d, 1'b0});
      last_due = d;
      exp_req_pc += 32'd4;
    end
    cyc++;
  endtask

  task automatic run(int n, int k, int pm, int pd, int pr);
    kfix = k;
    repeat (n) cycle($urandom_range(99) < pr, $urandom, $urandom_range(99) < pm, $urandom_range(99) < pd);
  endtask

  task automatic hit_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
    check("rst_instr", instruction, NOP);
    check("rst_pc", pc, 32'h0);
    mq.delete();
    pend.delete();
    exp_req_pc = 32'h0;
    last_due = cyc;
    @(negedge clk);
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect = 1'b0;
    inst_ready = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    redirect = 1'b0;
    redirect_pc = '0;
    inst_ready = 1'b0;
    #12;
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
    check("rst_instr", instruction, NOP);
    check("rst_pc", pc, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run(4, 1, 100, 100, 0);
    n_vld = 0;
    run(16, 1, 100, 100, 0);
    check("throughput", n_vld, 16);
    cycle(1'b1, 32'h0, 1'b1, 1'b1);
    kfix = 1;
    repeat (12) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    check("stall_req_off", {31'b0, imem_req_valid}, 32'h0);
    check("stall_head_pc", pc, 32'h0);
    run(20, 1, 100, 100, 0);
    run(6, 3, 100, 100, 0);
    cycle(1'b1, 32'h0000_0102, 1'b1, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    check("redir_addr", imem_addr, 32'h0000_0100);
    run(12, 3, 100, 100, 0);
    kfix = 2;
    for (int i = 0; i < 24; i++) cycle(1'b0, 32'h0, (i % 4 == 0) || (i % 4 == 3), 1'b1);
    cycle(1'b1, 32'hFFFF_FFF1, 1'b1, 1'b1);
    run(14, 1, 100, 100, 0);
    run(600, 0, 70, 60, 5);
    cycle(1'b1, 32'h0000_0040, 1'b1, 1'b0);
    kfix = 1;
    for (int i = 0; i < 20 && mq.size() != 3; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    check("pre_rst_valid", {31'b0, inst_valid}, 32'h1);
    hit_reset();
    run(20, 1, 100, 100, 0);
    run(200, 0, 80, 70, 4);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
